// File: rtl/xnor6_serial_decoder.sv
// Bit-serial XNOR operand recovery: g = ~(f ^ h), LSB first, one bit per clock.
// Reports the recovered operand, an f==g flag and the count of zero bits in h.
module xnor6_serial_decoder #(
    parameter int unsigned WIDTH = 6,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] f_in,
    input  logic [WIDTH-1:0] h_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g_out,
    output logic             eq_out,
    output logic [CW-1:0]    mism_cnt
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] f_sr_q;
    logic [WIDTH-1:0] h_sr_q;
    logic [WIDTH-1:0] g_sr_q;
    logic [WIDTH-1:0] g_sr_d;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             g_bit_d;

    assign in_ready = (state_q == IDLE);

    // f/h shift right so bit 0 is always the current position; g is written at idx.
    always_comb begin
        g_bit_d = ~(f_sr_q[0] ^ h_sr_q[0]);
        cnt_d   = h_sr_q[0] ? cnt_q : cnt_q + CW'(1);
        g_sr_d  = g_sr_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (idx_q == IW'(i)) begin
                g_sr_d[i] = g_bit_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            f_sr_q    <= '0;
            h_sr_q    <= '0;
            g_sr_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            g_out     <= '0;
            eq_out    <= 1'b0;
            mism_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        f_sr_q  <= f_in;
                        h_sr_q  <= h_in;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    f_sr_q <= f_sr_q >> 1;
                    h_sr_q <= h_sr_q >> 1;
                    g_sr_q <= g_sr_d;
                    cnt_q  <= cnt_d;
                    idx_q  <= idx_q + IW'(1);
                    if (idx_q == IW'(WIDTH - 1)) begin
                        g_out     <= g_sr_d;
                        mism_cnt  <= cnt_d;
                        eq_out    <= (cnt_d == '0);
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
